serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller. It accepts two WIDTH-bit unsigned operands on a start pulse and drives a single-bit subtractor cell once per clock, LSB first, carrying the borrow in a flip-flop. It returns the WIDTH-bit difference and the final borrow with a one-cycle done pulse. It sits between a requester and the one-bit subtraction datapath, trading latency for a single shared cell.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_sub.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 99 +++++++++
 tb/tb_serial_sub_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtraction controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: two half-subtractor stages with OR-ed borrows.
// Latency: combinational.
// Backpressure: none, pure logic.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b: drives one full_sub cell per clock, LSB first, borrow kept in a flop.
// Latency: done pulses WIDTH cycles after the accepting edge; busy clears one cycle later.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d;
    logic             bout;

    full_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // Result fills from the MSB side so the LSB lands in bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_next = d;
        end else begin : g_wn
            assign res_next = {d, res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bin        <= 1'b0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b;
                        bin   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bin    <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bout;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1) against a cycle-count arithmetic model.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         borrow1;

    int tests = 0;
    int fails = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Model: an accepted request is a countdown; at WIDTH cycles the answer is a-b.
    int           m_cnt;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W-1:0] m_diff;
    logic         m_bo;
    logic         m_done;
    logic         m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = -1;
            m_a    = '0;
            m_b    = '0;
            m_diff = '0;
            m_bo   = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt < 0) begin
                if (start) begin
                    m_cnt  = 0;
                    m_a    = a;
                    m_b    = b;
                    m_busy = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_done = 1'b1;
                    m_diff = m_a - m_b;
                    m_bo   = (m_a < m_b);
                end else if (m_cnt == W + 1) begin
                    m_cnt  = -1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            check("busy_vs_model", 32'(busy), 32'(m_busy));
            check("done_vs_model", 32'(done), 32'(m_done));
            check("diff_vs_model", 32'(diff), 32'(m_diff));
            check("borrow_vs_model", 32'(borrow_out), 32'(m_bo));
        end
    end

    // Index 0 is the negedge right after the accepting edge.
    task automatic wait_done(input int i0, output int lat);
        lat = -1;
        for (int i = i0; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hC3;
        wait_done(0, lat);
    endtask

    task automatic op_check(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [W-1:0] ed, input logic eb);
        int lat;
        run_op(ia, ib, lat);
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_borrow"}, 32'(borrow_out), 32'(eb));
        @(negedge clk);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
        check({name, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int extra;
        int pulses[$];
        logic [0:0] t_a [3];
        logic [0:0] t_b [3];
        logic [0:0] t_d [3];
        logic       t_bo[3];

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;

        op_check("op_35_12", 8'h35, 8'h12, 8'h23, 1'b0);
        check("model_pin_23", 32'(m_diff), 32'h23);
        op_check("op_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        check("model_pin_ff", 32'(m_diff), 32'hFF);
        op_check("op_aa_aa", 8'hAA, 8'hAA, 8'h00, 1'b0);

        // start held with new operands during SHIFT must not disturb the operation
        @(negedge clk);
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h01;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_done(4, lat);
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_diff", 32'(diff), 32'h7F);
        check("ignore_borrow", 32'(borrow_out), 32'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignore_single_done", 32'(extra), 32'd0);

        // reset mid-SHIFT
        @(negedge clk);
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_diff", 32'(diff), 32'd0);
        check("midreset_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_check("post_reset_10_20", 8'h10, 8'h20, 8'hF0, 1'b1);

        // back-to-back with start held continuously
        @(negedge clk);
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h03;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(c);
                check("b2b_diff", 32'(diff), 32'h02);
                check("b2b_borrow", 32'(borrow_out), 32'd0);
            end
        end
        start = 1'b0;
        check("b2b_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() > 0) check("b2b_first_latency", 32'(pulses[0]), 32'd8);
        for (int k = 1; k < pulses.size(); k++)
            check("b2b_spacing", 32'(pulses[k] - pulses[k-1]), 32'd10);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                lat = i;
                break;
            end
        end
        check("b2b_drain", 32'(lat >= 0), 32'd1);

        // WIDTH=1 instance
        t_a  = '{1'b0, 1'b1, 1'b1};
        t_b  = '{1'b1, 1'b0, 1'b1};
        t_d  = '{1'b1, 1'b1, 1'b0};
        t_bo = '{1'b1, 1'b0, 1'b0};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1     = t_a[v];
            b1     = t_b[v];
            @(negedge clk);
            start1 = 1'b0;
            a1     = ~t_a[v];
            b1     = ~t_b[v];
            lat = -1;
            for (int i = 0; i <= 10; i++) begin
                if (done1) begin
                    lat = i;
                    break;
                end
                @(negedge clk);
            end
            check("w1_latency", 32'(lat), 32'd1);
            check("w1_diff", 32'(diff1), 32'(t_d[v]));
            check("w1_borrow", 32'(borrow1), 32'(t_bo[v]));
            @(negedge clk);
            check("w1_busy_fall", 32'(busy1), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
